fft_input_loader: RTL
=====================

Name: fft_input_loader

Overview:
- Front-end stage of the 16-point FFT; sits directly upstream of the stage sequencer and butterfly datapath.
- Accepts a serial stream of complex samples over a valid/ready handshake.
- Stores each sample at its bit-reversed index so the datapath sees decimation-in-time order.
- Presents a complete frame in parallel, then holds it until the core acknowledges it has captured the frame.

Parameters:
- N_POINTS, 16, FFT size; power of two.
- LOG2N, 4, log2(N_POINTS); sample-index width.
- DATA_W, 16, signed width of each real and imaginary component.

Ports:
- i_clk  input  1  clock.
- i_rst  input  1  reset, asynchronous, active-high.
- i_flush  input  1  synchronous discard of a partially filled frame.
- i_valid  input  1  upstream sample valid.
- i_re  input  DATA_W  sample real part, signed.
- i_im  input  DATA_W  sample imaginary part, signed.
- o_ready  output  1  loader can accept a sample this cycle.
- o_frame_valid  output  1  all N_POINTS slots are filled; frame outputs are stable.
- o_frame_re  output  N_POINTS*DATA_W  real parts; slot k occupies bits [k*DATA_W +: DATA_W].
- o_frame_im  output  N_POINTS*DATA_W  imaginary parts; same packing as o_frame_re.
- i_frame_ack  input  1  core has captured the frame; one-cycle pulse.
- o_fill_cnt  output  LOG2N+1  number of samples held, 0..N_POINTS.

Behaviour:
- Reset (async, i_rst=1):
  - State becomes FILL; write counter = 0.
  - o_ready=1, o_frame_valid=0, o_fill_cnt=0.
  - All sample slots cleared to 0.
- States:
  - FILL: o_ready=1, o_frame_valid=0.
  - FULL: o_ready=0, o_frame_valid=1.
- Accept rule:
  - A sample is accepted on a rising edge where i_valid && o_ready.
  - It is written to slot bitrev(cnt), where bitrev reverses the LOG2N bits of the counter.
  - Example: cnt 1 -> slot 8; cnt 3 -> slot 12; cnt 6 -> slot 6.
  - The counter then increments.
- FILL -> FULL:
  - Triggered on the edge that accepts sample N_POINTS-1.
  - The counter wraps to 0.
  - o_frame_valid is 1 in the cycle after the last accept (latency 1 from last handshake).
  - o_fill_cnt = N_POINTS while in FULL.
- FULL -> FILL:
  - Triggered on the edge where i_frame_ack=1.
  - o_ready returns to 1 the next cycle.
  - No sample is accepted on the ack edge itself, since o_ready=0 during FULL.
- Data retention:
  - Slot contents are never modified while in FULL.
  - After the ack, slots keep their old values until overwritten; only o_frame_valid qualifies them.
- i_frame_ack in FILL: ignored.
- i_flush:
  - In FILL: the counter returns to 0 and any sample presented on the same edge is dropped.
  - In FULL: ignored; a completed frame is never discarded.
- Flush priority: i_flush takes priority over an accept on the same edge.
- Backpressure: i_valid=0 stalls the counter; gaps in the stream are allowed anywhere.
- Reset mid-fill or mid-FULL: the partial or complete frame is lost and outputs return to their reset values immediately (asynchronous).
- Arithmetic: samples are stored verbatim, with no scaling or sign extension.

Decomposition:
- Shared fft_pkg holds:
  - N_POINTS, LOG2N, DATA_W;
  - the bit-reverse function;
  - the state encoding localparams: FILL=1'b0, FULL=1'b1.
- One natural sub-module: fft_bitrev_addr. It is a combinational LOG2N-bit reverser, reused later by the output reorder stage.

Test Plan:
- Ordered fill: after reset, stream re=k, im=-k for k=0..15 with i_valid held high.
  - Required: o_frame_valid rises 1 cycle after the 16th handshake.
  - Required: slot 8 = (1,-1), slot 12 = (3,-3), slot 15 = (15,-15).
  - Required: o_ready=0 while o_frame_valid=1.
- Hold and ack: keep frame FULL for 10 cycles while driving i_valid=1 with new data.
  - Required: outputs unchanged.
  - Pulse i_frame_ack. Required: o_ready=1 the next cycle; the next accept writes slot 0.
- Bubbled input: i_valid toggles 1,0,1,0 over 32 cycles.
  - Required: frame completes after exactly 16 handshakes, with same slot mapping as the ordered-fill case.
  - Required: o_fill_cnt tracks each handshake.
- Flush mid-frame: accept 5 samples, then assert i_flush together with i_valid.
  - Required: o_fill_cnt=0 and that sample dropped.
  - Required: the next 16 samples form a correct frame.
  - Repeat with i_flush asserted during FULL. Required: no effect.
- Async reset: assert i_rst between clock edges at fill count 9.
  - Required: o_fill_cnt=0, o_frame_valid=0, o_ready=1 before the next edge.
- Back-to-back frames: two 16-sample frames, with ack pulsed the cycle o_frame_valid rises.
  - Required: the second frame completes 17 cycles after the ack (1 cycle ready turnaround plus 16 accepts), with correct contents.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared definitions for the 16-point FFT: sizes, state encoding and the
// bit-reverse helper used to map stream order onto decimation-in-time order.
package fft_pkg;

  localparam int N_POINTS = 16;
  localparam int LOG2N    = 4;
  localparam int DATA_W   = 16;

  // Loader state encoding: FILL collects samples, FULL holds a complete frame.
  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } loader_state_e;

  // Reverse the LOG2N bits of a sample index (index 1 -> 8, 3 -> 12, 6 -> 6).
  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] idx);
    logic [LOG2N-1:0] rev;
    rev = {LOG2N{1'b0}};
    for (int b = 0; b < LOG2N; b++) begin
      rev[b] = idx[LOG2N-1-b];
    end
    return rev;
  endfunction

endpackage

// File: rtl/fft_bitrev_addr.sv
// Combinational LOG2N-bit index reverser; shared with the output reorder stage.
module fft_bitrev_addr
  import fft_pkg::*;
(
  input  logic [LOG2N-1:0] idx,
  output logic [LOG2N-1:0] rev_idx
);

  // Pure wiring: swap bit order of the incoming index.
  always_comb begin
    rev_idx = bitrev(idx);
  end

endmodule

// File: rtl/fft_input_loader.sv
// FFT front end: takes a serial valid/ready sample stream, stores each sample
// at its bit-reversed slot, and presents the complete frame in parallel until
// the core acknowledges it.
module fft_input_loader
  import fft_pkg::*;
(
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_flush,
  input  logic                         i_valid,
  input  logic [DATA_W-1:0]            i_re,
  input  logic [DATA_W-1:0]            i_im,
  output logic                         o_ready,
  output logic                         o_frame_valid,
  output logic [N_POINTS*DATA_W-1:0]   o_frame_re,
  output logic [N_POINTS*DATA_W-1:0]   o_frame_im,
  input  logic                         i_frame_ack,
  output logic [LOG2N:0]               o_fill_cnt
);

  localparam logic [LOG2N:0] CNT_ZERO = {(LOG2N+1){1'b0}};
  localparam logic [LOG2N:0] CNT_ONE  = (LOG2N+1)'(1);
  localparam logic [LOG2N:0] CNT_LAST = (LOG2N+1)'(N_POINTS - 1);
  localparam logic [LOG2N:0] CNT_FULL = (LOG2N+1)'(N_POINTS);

  loader_state_e      state_r;
  loader_state_e      state_next_s;
  logic [LOG2N:0]     fill_cnt_r;
  logic [LOG2N:0]     fill_next_s;
  logic               accept_s;
  logic [LOG2N-1:0]   wr_addr_s;

  logic [DATA_W-1:0]  re_r [N_POINTS];
  logic [DATA_W-1:0]  im_r [N_POINTS];

  // The low LOG2N bits of the fill count are the stream index; reversed they
  // give the storage slot.
  fft_bitrev_addr u_bitrev (
    .idx     (fill_cnt_r[LOG2N-1:0]),
    .rev_idx (wr_addr_s)
  );

  // State and fill-count registers; fill count doubles as the write counter.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_r    <= FILL;
      fill_cnt_r <= CNT_ZERO;
    end else begin
      state_r    <= state_next_s;
      fill_cnt_r <= fill_next_s;
    end
  end

  // Next-state logic: flush beats accept in FILL; flush is ignored in FULL so
  // a completed frame is never discarded.
  always_comb begin
    state_next_s = state_r;
    fill_next_s  = fill_cnt_r;
    accept_s     = 1'b0;
    case (state_r)
      FILL: begin
        if (i_flush) begin
          fill_next_s = CNT_ZERO;
        end else if (i_valid) begin
          accept_s = 1'b1;
          if (fill_cnt_r == CNT_LAST) begin
            state_next_s = FULL;
            fill_next_s  = CNT_FULL;
          end else begin
            fill_next_s = fill_cnt_r + CNT_ONE;
          end
        end else begin
          fill_next_s = fill_cnt_r;
        end
      end
      FULL: begin
        if (i_frame_ack) begin
          state_next_s = FILL;
          fill_next_s  = CNT_ZERO;
        end else begin
          state_next_s = FULL;
        end
      end
      default: begin
        state_next_s = FILL;
        fill_next_s  = CNT_ZERO;
      end
    endcase
  end

  // Sample storage: written only on an accepted handshake, so contents are
  // frozen in FULL and persist after the ack until overwritten.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < N_POINTS; i++) begin
        re_r[i] <= {DATA_W{1'b0}};
        im_r[i] <= {DATA_W{1'b0}};
      end
    end else if (accept_s) begin
      re_r[wr_addr_s] <= i_re;
      im_r[wr_addr_s] <= i_im;
    end
  end

  // Flatten slot storage onto the parallel frame buses.
  for (genvar k = 0; k < N_POINTS; k++) begin : g_pack
    assign o_frame_re[k*DATA_W +: DATA_W] = re_r[k];
    assign o_frame_im[k*DATA_W +: DATA_W] = im_r[k];
  end

  assign o_ready       = (state_r == FILL);
  assign o_frame_valid = (state_r == FULL);
  assign o_fill_cnt    = fill_cnt_r;

endmodule
